// File: rtl/jtcontra_pcm_pkg.sv
// Shared definitions for the Konami PCM sample player: register map,
// control bit positions and fetch FSM states.
package jtcontra_pcm_pkg;

  localparam logic [2:0] REG_SEL  = 3'd0;
  localparam logic [2:0] REG_ST0  = 3'd1;
  localparam logic [2:0] REG_ST1  = 3'd2;
  localparam logic [2:0] REG_ST2  = 3'd3;
  localparam logic [2:0] REG_LEN0 = 3'd4;
  localparam logic [2:0] REG_LEN1 = 3'd5;
  localparam logic [2:0] REG_CTRL = 3'd6;

  localparam int unsigned CTRL_PLAY    = 0;
  localparam int unsigned CTRL_LOOP    = 1;
  localparam int unsigned CTRL_VOL_LSB = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_NEXT,
    ST_MIX
  } state_t;

endpackage

// File: rtl/jtcontra_pcm_ch.sv
// One PCM channel: CPU-visible registers, playback pointer/counter,
// end-of-sample and loop handling, and the held signed sample.
module jtcontra_pcm_ch
  import jtcontra_pcm_pkg::*;
#(
  parameter int AW = 17,
  parameter int LW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [2:0]        addr,
  input  logic [7:0]        din,
  input  logic              done,
  input  logic              clr,
  input  logic [7:0]        rom_data,
  output logic              busy,
  output logic [AW-1:0]     ptr,
  output logic signed [7:0] smp,
  output logic [3:0]        vol
);

  logic [AW-1:0]     start_q, start_d, ptr_q, ptr_d;
  logic [LW-1:0]     len_q, len_d, act_len_q, act_len_d, cnt_q, cnt_d, cnt_inc;
  logic              loop_q, loop_d, act_loop_q, act_loop_d, busy_q, busy_d;
  logic [3:0]        vol_q, vol_d;
  logic signed [7:0] smp_q, smp_d;

  always_comb begin
    start_d    = start_q;
    len_d      = len_q;
    loop_d     = loop_q;
    vol_d      = vol_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    act_len_d  = act_len_q;
    act_loop_d = act_loop_q;
    smp_d      = smp_q;
    cnt_inc    = cnt_q + LW'(1);

    if (done) begin
      smp_d = rom_data ^ 8'h80;
      ptr_d = ptr_q + AW'(1);
      cnt_d = cnt_inc;
      if (cnt_inc == act_len_q) begin
        if (act_loop_q) begin
          // reload picks up any start/length/loop written since the trigger
          ptr_d      = start_q;
          cnt_d      = '0;
          act_len_d  = len_q;
          act_loop_d = loop_q;
          if (len_q == '0) busy_d = 1'b0;
        end else begin
          busy_d = 1'b0;
        end
      end
    end
    if (clr) smp_d = '0;

    if (we) begin
      case (addr)
        REG_ST0:  start_d[7:0]  = din;
        REG_ST1:  start_d[15:8] = din;
        REG_ST2:  start_d       = AW'({din, start_q[15:0]});
        REG_LEN0: len_d[7:0]    = din;
        REG_LEN1: len_d[15:8]   = din;
        REG_CTRL: begin
          loop_d = din[CTRL_LOOP];
          vol_d  = din[CTRL_VOL_LSB +: 4];
          ptr_d  = ptr_q;
          cnt_d  = cnt_q;
          busy_d = 1'b0;
          if (din[CTRL_PLAY]) begin
            ptr_d      = start_q;
            cnt_d      = '0;
            busy_d     = (len_q != '0);
            act_len_d  = len_q;
            act_loop_d = din[CTRL_LOOP];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q    <= '0;
      len_q      <= '0;
      loop_q     <= 1'b0;
      vol_q      <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      act_len_q  <= '0;
      act_loop_q <= 1'b0;
      smp_q      <= '0;
    end else begin
      start_q    <= start_d;
      len_q      <= len_d;
      loop_q     <= loop_d;
      vol_q      <= vol_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      act_len_q  <= act_len_d;
      act_loop_q <= act_loop_d;
      smp_q      <= smp_d;
    end
  end

  assign busy = busy_q;
  assign ptr  = ptr_q;
  assign smp  = smp_q;
  assign vol  = vol_q;

endmodule

// File: rtl/jtcontra_pcm_player.sv
// Multi-channel 8-bit PCM player: Z80 bus decode, round-robin ROM fetch
// FSM and the volume-weighted mixer producing one sample per cen_smp.
module jtcontra_pcm_player
  import jtcontra_pcm_pkg::*;
#(
  parameter int CH = 2,
  parameter int AW = 17,
  parameter int LW = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cen_smp,
  input  logic                           cpu_cen,
  input  logic                           cs,
  input  logic                           wr_n,
  input  logic [2:0]                     addr,
  input  logic [7:0]                     din,
  output logic [7:0]                     dout,
  output logic [AW-1:0]                  rom_addr,
  output logic                           rom_cs,
  input  logic [7:0]                     rom_data,
  input  logic                           rom_ok,
  output logic signed [12+$clog2(CH)-1:0] snd,
  output logic                           sample
);

  localparam int SNDW = 12 + $clog2(CH);
  localparam logic [1:0] SEL_MASK = 2'((1 << $clog2(CH)) - 1);

  state_t                 state_q, state_d;
  logic [2:0]             k_q, k_d, j;
  logic [1:0]             sel_q, sel_d;
  logic                   rom_cs_q, rom_cs_d, sample_q, sample_d;
  logic                   overrun_q, overrun_d, found, wr_en, rd_en;
  logic [AW-1:0]          rom_addr_q, rom_addr_d, pick_addr;
  logic signed [SNDW-1:0] snd_q, snd_d, mix_sum;
  logic [7:0]             dout_q, dout_d;
  logic signed [12:0]     a13, v13, prod;
  logic [3:0]             busy4;

  logic [CH-1:0]     busy_w, ch_we, done_w, clr_w;
  logic [AW-1:0]     ptr_w [CH];
  logic signed [7:0] smp_w [CH];
  logic [3:0]        vol_w [CH];

  assign wr_en = cpu_cen & cs & ~wr_n;
  assign rd_en = cpu_cen & cs & wr_n;
  assign busy4 = 4'(busy_w);

  always_comb begin
    for (int unsigned i = 0; i < CH; i++)
      ch_we[i] = wr_en && (sel_q == 2'(i)) && (addr != REG_SEL) && (addr != 3'd7);
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    jtcontra_pcm_ch #(.AW(AW), .LW(LW)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (ch_we[g]),
      .addr     (addr),
      .din      (din),
      .done     (done_w[g]),
      .clr      (clr_w[g]),
      .rom_data (rom_data),
      .busy     (busy_w[g]),
      .ptr      (ptr_w[g]),
      .smp      (smp_w[g]),
      .vol      (vol_w[g])
    );
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    sel_d      = sel_q;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    snd_d      = snd_q;
    sample_d   = 1'b0;
    overrun_d  = overrun_q;
    dout_d     = dout_q;
    done_w     = '0;
    clr_w      = '0;
    found      = 1'b0;
    j          = '0;
    pick_addr  = '0;
    mix_sum    = '0;
    a13        = '0;
    v13        = '0;
    prod       = '0;

    // NEXT skips every idle channel in one cycle, so only busy ones cost time
    for (int unsigned i = 0; i < CH; i++) begin
      if (!found && 3'(i) >= k_q && busy_w[i]) begin
        found     = 1'b1;
        j         = 3'(i);
        pick_addr = ptr_w[i];
      end
    end
    // skipped channels are zeroed this cycle, so they are masked out of the sum
    for (int unsigned i = 0; i < CH; i++) begin
      a13     = (3'(i) < k_q) ? 13'(smp_w[i]) : '0;
      v13     = {9'd0, vol_w[i]};
      prod    = a13 * v13;
      mix_sum = mix_sum + SNDW'(prod);
    end

    if (wr_en && addr == REG_SEL) sel_d = din[1:0] & SEL_MASK;
    if (rd_en) begin
      dout_d    = {overrun_q, 3'b000, busy4};
      overrun_d = 1'b0;
    end
    if (cen_smp && state_q != ST_IDLE) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: if (cen_smp) begin
        k_d     = '0;
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        for (int unsigned i = 0; i < CH; i++)
          if (3'(i) >= k_q && (!found || 3'(i) < j)) clr_w[i] = 1'b1;
        if (found) begin
          k_d        = j;
          rom_cs_d   = 1'b1;
          rom_addr_d = pick_addr;
          state_d    = ST_REQ;
        end else begin
          snd_d    = mix_sum;
          sample_d = 1'b1;
          state_d  = ST_MIX;
        end
      end
      ST_REQ: state_d = ST_WAIT;
      ST_WAIT: if (rom_ok) begin
        for (int unsigned i = 0; i < CH; i++)
          if (3'(i) == k_q) done_w[i] = 1'b1;
        rom_cs_d = 1'b0;
        k_d      = k_q + 3'd1;
        state_d  = ST_NEXT;
      end
      ST_MIX: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      sel_q      <= '0;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      snd_q      <= '0;
      sample_q   <= 1'b0;
      overrun_q  <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      sel_q      <= sel_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      snd_q      <= snd_d;
      sample_q   <= sample_d;
      overrun_q  <= overrun_d;
      dout_q     <= dout_d;
    end
  end

  assign rom_cs   = rom_cs_q;
  assign rom_addr = rom_addr_q;
  assign snd      = snd_q;
  assign sample   = sample_q;
  assign dout     = dout_q;

endmodule
